als_light_filter: RTL and testbench

- Downstream consumer of the PmodALS SPI receiver's 16-bit raw frame.
- Validates the frame format, extracts the 8-bit light sample, and keeps a moving average over 2^AVG_LOG2 samples.
- Produces a hysteretic dark/bright flag and an 8-LED bar graph for the board display logic.

---
 rtl/als_pkg.sv | 24 ++
 rtl/als_hysteresis.sv | 38 +++
 rtl/als_light_filter.sv | 146 ++++++++++++++
 tb/tb_als_light_filter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/als_pkg.sv
// Shared constants, state encoding and bar-graph helper for the ALS light filter.
package als_pkg;

    localparam int ALS_LIGHT_MSB = 11;
    localparam int ALS_LIGHT_LSB = 4;
    localparam int ALS_LIGHT_W   = 8;
    localparam int ALS_FRAME_W   = 16;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } als_state_e;

    // Thermometer code: LED i lights when the level exceeds 32*i.
    function automatic logic [ALS_LIGHT_W-1:0] als_bar(input logic [ALS_LIGHT_W-1:0] lvl);
        logic [ALS_LIGHT_W-1:0] b;
        b = '0;
        for (int i = 0; i < ALS_LIGHT_W; i++) begin
            b[i] = (lvl > ALS_LIGHT_W'(32 * i));
        end
        return b;
    endfunction

endpackage

// File: rtl/als_hysteresis.sv
// Registered dark/bright flag with a dead band between DARK_LO and DARK_HI.
module als_hysteresis
    import als_pkg::*;
#(
    parameter logic [ALS_LIGHT_W-1:0] DARK_LO = 8'd40,
    parameter logic [ALS_LIGHT_W-1:0] DARK_HI = 8'd60
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [ALS_LIGHT_W-1:0] level_i,
    input  logic                   update_i,
    output logic                   dark_o
);

    logic dark_d, dark_q;

    always_comb begin
        dark_d = dark_q;
        if (update_i) begin
            if (level_i < DARK_LO) begin
                dark_d = 1'b1;
            end else if (level_i > DARK_HI) begin
                dark_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dark_q <= 1'b0;
        end else begin
            dark_q <= dark_d;
        end
    end

    assign dark_o = dark_q;

endmodule

// File: rtl/als_light_filter.sv
// Frame check, moving average, hysteretic dark flag and LED bar for PmodALS samples.
// Optional min/max tracking of the averages is enabled by defining ALS_MINMAX_EN.
module als_light_filter
    import als_pkg::*;
#(
    parameter int                     AVG_LOG2 = 3,
    parameter logic [ALS_LIGHT_W-1:0] DARK_LO  = 8'd40,
    parameter logic [ALS_LIGHT_W-1:0] DARK_HI  = 8'd60
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [ALS_FRAME_W-1:0] raw_value,
    input  logic                   raw_valid,
    output logic [ALS_LIGHT_W-1:0] avg_level,
    output logic                   avg_valid,
    output logic                   dark,
    output logic [ALS_LIGHT_W-1:0] bar,
    output logic                   fmt_err
`ifdef ALS_MINMAX_EN
    ,
    output logic [ALS_LIGHT_W-1:0] min_level,
    output logic [ALS_LIGHT_W-1:0] max_level
`endif
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = ALS_LIGHT_W + AVG_LOG2;

    als_state_e                 state_q, state_d;
    logic [AVG_LOG2-1:0]        fill_q, fill_d;
    logic [AVG_LOG2-1:0]        wptr_q;
    logic [SUM_W-1:0]           sum_q;
    logic [ALS_LIGHT_W-1:0]     ring_q [DEPTH];
    logic [ALS_LIGHT_W-1:0]     avg_q;
    logic                       avg_valid_q;
    logic [ALS_LIGHT_W-1:0]     bar_q;
    logic                       fmt_err_q;

    logic                       frame_good;
    logic                       sample_ok;
    logic                       emit;
    logic [ALS_LIGHT_W-1:0]     light;
    logic [SUM_W-1:0]           new_sum;
    logic [ALS_LIGHT_W-1:0]     new_avg;

    always_comb begin
        frame_good = (raw_value[ALS_FRAME_W-1:ALS_LIGHT_MSB+1] == '0) &&
                     (raw_value[ALS_LIGHT_LSB-1:0] == '0);
        sample_ok  = raw_valid && frame_good;
        light      = raw_value[ALS_LIGHT_MSB:ALS_LIGHT_LSB];
        // The oldest entry is still zero during FILL, so the sum stays exact.
        new_sum    = sum_q + SUM_W'(light) - SUM_W'(ring_q[wptr_q]);
        new_avg    = ALS_LIGHT_W'(new_sum >> AVG_LOG2);
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        emit    = 1'b0;
        if (sample_ok) begin
            case (state_q)
                FILL: begin
                    fill_d = fill_q + 1'b1;
                    if (fill_q == AVG_LOG2'(DEPTH - 1)) begin
                        state_d = RUN;
                        emit    = 1'b1;
                    end
                end
                RUN:     emit = 1'b1;
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            fill_q      <= '0;
            wptr_q      <= '0;
            sum_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            bar_q       <= '0;
            fmt_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            avg_valid_q <= emit;
            if (raw_valid && !frame_good) begin
                fmt_err_q <= 1'b1;
            end
            if (sample_ok) begin
                sum_q  <= new_sum;
                wptr_q <= wptr_q + 1'b1;
            end
            if (emit) begin
                avg_q <= new_avg;
                bar_q <= als_bar(new_avg);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring_q[i] <= '0;
            end
        end else if (sample_ok) begin
            ring_q[wptr_q] <= light;
        end
    end

    als_hysteresis #(
        .DARK_LO (DARK_LO),
        .DARK_HI (DARK_HI)
    ) u_hyst (
        .clock    (clock),
        .reset_n  (reset_n),
        .level_i  (new_avg),
        .update_i (emit),
        .dark_o   (dark)
    );

    assign avg_level = avg_q;
    assign avg_valid = avg_valid_q;
    assign bar       = bar_q;
    assign fmt_err   = fmt_err_q;

`ifdef ALS_MINMAX_EN
    logic [ALS_LIGHT_W-1:0] min_q, max_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            min_q <= 8'hFF;
            max_q <= 8'h00;
        end else if (emit) begin
            if (new_avg < min_q) min_q <= new_avg;
            if (new_avg > max_q) max_q <= new_avg;
        end
    end

    assign min_level = min_q;
    assign max_level = max_q;
`endif

endmodule

// File: tb/tb_als_light_filter.sv
// Self-checking bench for als_light_filter: vector table feeding a per-cycle scoreboard.
module tb_als_light_filter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] raw_value = '0;
    logic        raw_valid = 1'b0;
    logic [7:0]  avg_level;
    logic        avg_valid;
    logic        dark;
    logic [7:0]  bar;
    logic        fmt_err;
`ifdef ALS_MINMAX_EN
    logic [7:0]  min_level;
    logic [7:0]  max_level;
`endif

    always #5 clock = ~clock;

    als_light_filter #(
        .AVG_LOG2 (3),
        .DARK_LO  (8'd40),
        .DARK_HI  (8'd60)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .raw_value (raw_value),
        .raw_valid (raw_valid),
        .avg_level (avg_level),
        .avg_valid (avg_valid),
        .dark      (dark),
        .bar       (bar),
        .fmt_err   (fmt_err)
`ifdef ALS_MINMAX_EN
        ,
        .min_level (min_level),
        .max_level (max_level)
`endif
    );

    typedef struct {
        logic [15:0] raw;
        bit          v;
        bit          ev;
        int          ea;
    } vec_t;

    typedef struct {
        bit v;
        int avg;
        bit dark;
        int bar;
        bit fmt;
        int mn;
        int mx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    int   m_avg, m_bar, m_min, m_max;
    bit   m_dark, m_fmt;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int therm(input int a);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) if (a > 32 * i) n++;
        return (1 << n) - 1;
    endfunction

    task automatic model_reset();
        m_avg = 0; m_bar = 0; m_dark = 0; m_fmt = 0; m_min = 255; m_max = 0;
    endtask

    task automatic add(input logic [15:0] raw, input bit v, input bit ev, input int ea);
        vec_t t;
        t.raw = raw; t.v = v; t.ev = ev; t.ea = ea;
        vecs.push_back(t);
    endtask

    // Drive one cycle; the expectation for the following cycle is queued after the edge.
    task automatic drive(input logic [15:0] raw, input bit v, input bit ev, input int ea);
        exp_t e;
        @(negedge clock);
        raw_value = raw;
        raw_valid = v;
        @(posedge clock);
        if (v && (raw[15:12] != 4'h0 || raw[3:0] != 4'h0)) m_fmt = 1;
        if (ev) begin
            m_avg = ea;
            if (ea < 40) m_dark = 1;
            else if (ea > 60) m_dark = 0;
            m_bar = therm(ea);
            if (ea < m_min) m_min = ea;
            if (ea > m_max) m_max = ea;
        end
        e.v = ev; e.avg = m_avg; e.dark = m_dark; e.bar = m_bar;
        e.fmt = m_fmt; e.mn = m_min; e.mx = m_max;
        sb.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_avg_level"}, int'(avg_level), 0);
        check({tag, "_avg_valid"}, int'(avg_valid), 0);
        check({tag, "_dark"},      int'(dark), 0);
        check({tag, "_bar"},       int'(bar), 0);
        check({tag, "_fmt_err"},   int'(fmt_err), 0);
`ifdef ALS_MINMAX_EN
        check({tag, "_min"}, int'(min_level), 255);
        check({tag, "_max"}, int'(max_level), 0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1;
        reset_n   = 1'b0;
        raw_valid = 1'b0;
        model_reset();
        #1;
        check_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("avg_valid", int'(avg_valid), int'(e.v));
            check("avg_level", int'(avg_level), e.avg);
            check("dark",      int'(dark), int'(e.dark));
            check("bar",       int'(bar), e.bar);
            check("fmt_err",   int'(fmt_err), int'(e.fmt));
`ifdef ALS_MINMAX_EN
            check("min_level", int'(min_level), e.mn);
            check("max_level", int'(max_level), e.mx);
`endif
        end else if (reset_n) begin
            check("stray_avg_valid", int'(avg_valid), 0);
        end
    end

    initial begin
        model_reset();

        // Fill with 100: first average only on the 8th good frame; an idle gap in between.
        for (int i = 0; i < 3; i++) add(16'h0640, 1, 0, 0);
        add(16'hFFFF, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(16'h0640, 1, 0, 0);
        add(16'h0640, 1, 1, 100);
        // Decay to zero: dark sets at 37.
        add(16'h0000, 1, 1, 87);
        add(16'h0000, 1, 1, 75);
        add(16'h0000, 1, 1, 62);
        add(16'h0000, 1, 1, 50);
        add(16'h0000, 1, 1, 37);
        add(16'h0000, 1, 1, 25);
        add(16'h0000, 1, 1, 12);
        add(16'h0000, 1, 1, 0);
        // Ramp to 50: dark holds inside the band.
        add(16'h0320, 1, 1, 6);
        add(16'h0320, 1, 1, 12);
        add(16'h0320, 1, 1, 18);
        add(16'h0320, 1, 1, 25);
        add(16'h0320, 1, 1, 31);
        add(16'h0320, 1, 1, 37);
        add(16'h0320, 1, 1, 43);
        add(16'h0320, 1, 1, 50);
        // Back toward 100: dark clears on the first average above 60.
        add(16'h0640, 1, 1, 56);
        add(16'h0640, 1, 1, 62);
        add(16'h0640, 1, 1, 68);
        // Malformed frames are dropped and latch fmt_err.
        add(16'h1640, 1, 0, 0);
        add(16'h0640, 1, 1, 75);
        add(16'h0641, 1, 0, 0);
        add(16'h0000, 0, 0, 0);
        add(16'h0640, 1, 1, 81);
        add(16'h0000, 0, 0, 0);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].raw, vecs[i].v, vecs[i].ev, vecs[i].ea);
        end

        // Back-to-back 255 after a reset that also clears the sticky fmt_err.
        do_reset();
        for (int i = 0; i < 7; i++) drive(16'h0FF0, 1, 0, 0);
        drive(16'h0FF0, 1, 1, 255);
        drive(16'h0FF0, 1, 1, 255);
        drive(16'h0FF0, 1, 1, 255);

        // Reset mid-cycle while a sample is presented.
        @(negedge clock);
        raw_value = 16'h0FF0;
        raw_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        sb.delete();
        model_reset();
        #1;
        check_zero("midreset");
        @(negedge clock);
        raw_valid = 1'b0;
        reset_n   = 1'b1;

        // FILL must restart: seven quiet samples, then the first average.
        for (int i = 0; i < 7; i++) drive(16'h0640, 1, 0, 0);
        drive(16'h0640, 1, 1, 100);
        drive(16'h0000, 0, 0, 0);

        @(negedge clock);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
